// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package instr_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ASSEMBLE,
    WRITE,
    RELEASE,
    DONE
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_STEP      = 4;

endpackage

// File: rtl/instr_loader_word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words; word_valid marks the byte completing a word.
module word_assembler
  import instr_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_valid
);

  // Only the three earlier bytes need storing; the fourth arrives on byte_in.
  logic [23:0] shreg;
  logic [1:0]  byte_cnt;

  assign word_next  = {shreg, byte_in};
  assign word_valid = load && (byte_cnt == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (clear) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      shreg    <= word_next[23:0];
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a byte stream into CPU instruction memory, holding the CPU in reset until the image is complete.
//   state    | meaning
//   IDLE     | power-up, CPU held in reset, waiting for start
//   ASSEMBLE | accepting stream bytes into the current word
//   WRITE    | one cycle presenting the completed word to memory
//   RELEASE  | initialize low, cpu_rst held for RST_CYCLES
//   DONE     | CPU running; a new start reloads
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          LEN_W      = 8,
  parameter int          RST_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] num_words,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             initialize,
  output logic [31:0]      instruction_initialize_data,
  output logic [31:0]      instruction_initialize_address,
  output logic             cpu_rst,
  output logic             busy,
  output logic             done
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  state_t           state;
  logic [LEN_W-1:0] num_words_q;
  logic [LEN_W-1:0] word_cnt;
  logic [RC_W-1:0]  rel_cnt;
  logic             fire;
  logic             asm_clear;
  logic             word_valid;
  logic [31:0]      word_next;

  assign in_ready  = (state == ASSEMBLE);
  assign fire      = in_valid && in_ready;
  assign asm_clear = start && ((state == IDLE) || (state == DONE));

  word_assembler u_word_assembler (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .load       (fire),
    .byte_in    (in_data),
    .word_next  (word_next),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                          <= IDLE;
      num_words_q                    <= '0;
      word_cnt                       <= '0;
      rel_cnt                        <= '0;
      initialize                     <= 1'b0;
      instruction_initialize_data    <= '0;
      instruction_initialize_address <= BASE_ADDR;
      cpu_rst                        <= 1'b1;
      busy                           <= 1'b0;
      done                           <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            num_words_q                    <= num_words;
            word_cnt                       <= '0;
            rel_cnt                        <= RC_W'(RST_CYCLES - 1);
            instruction_initialize_address <= BASE_ADDR;
            instruction_initialize_data    <= '0;
            initialize                     <= 1'b1;
            cpu_rst                        <= 1'b1;
            busy                           <= 1'b1;
            done                           <= 1'b0;
            state                          <= (num_words == '0) ? RELEASE : ASSEMBLE;
          end
        end
        ASSEMBLE: begin
          if (word_valid) begin
            instruction_initialize_data    <= word_next;
            instruction_initialize_address <= BASE_ADDR + 32'(word_cnt) * 32'(ADDR_STEP);
            word_cnt                       <= word_cnt + 1'b1;
            state                          <= WRITE;
          end
        end
        WRITE: begin
          // word_cnt was bumped on entry, so equality means this was the last word.
          if (word_cnt == num_words_q) begin
            initialize <= 1'b0;
            rel_cnt    <= RC_W'(RST_CYCLES - 1);
            state      <= RELEASE;
          end else begin
            state <= ASSEMBLE;
          end
        end
        RELEASE: begin
          initialize <= 1'b0;
          if (rel_cnt == '0) begin
            cpu_rst <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            rel_cnt <= rel_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomized scoreboard bench for instr_loader with a memory model standing in for the CPU.
module tb_instr_loader;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          RSTC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  num_words = '0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        initialize;
  logic [31:0] instruction_initialize_data;
  logic [31:0] instruction_initialize_address;
  logic        cpu_rst;
  logic        busy;
  logic        done;

  instr_loader #(.BASE_ADDR(BASE), .LEN_W(8), .RST_CYCLES(RSTC)) dut (
    .clk                            (clk),
    .rst                            (rst),
    .start                          (start),
    .num_words                      (num_words),
    .in_data                        (in_data),
    .in_valid                       (in_valid),
    .in_ready                       (in_ready),
    .initialize                     (initialize),
    .instruction_initialize_data    (instruction_initialize_data),
    .instruction_initialize_address (instruction_initialize_address),
    .cpu_rst                        (cpu_rst),
    .busy                           (busy),
    .done                           (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic [63:0] exp_q[$];
  logic [31:0] mem [logic [31:0]];
  logic [7:0]  bb [0:63];

  int first_acc, last_wr, init_fall, done_cyc;
  bit prev_rdy, prev_init, prev_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: emulates the instruction memory and pops the scoreboard on each WRITE cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_rdy  = 1'b0;
      prev_init = 1'b0;
      prev_done = 1'b0;
    end else begin
      logic [63:0] e;
      if (initialize) mem[instruction_initialize_address] = instruction_initialize_data;
      if (in_ready && in_valid && first_acc < 0) first_acc = cyc;
      if (initialize && !in_ready && prev_rdy) begin
        last_wr = cyc;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: addr %h data %h", instruction_initialize_address,
                   instruction_initialize_data);
        end else begin
          e = exp_q.pop_front();
          chk("write_addr", instruction_initialize_address, e[63:32]);
          chk("write_data", instruction_initialize_data, e[31:0]);
        end
      end
      if (!initialize && prev_init && init_fall < 0) init_fall = cyc;
      if (done && !prev_done && done_cyc < 0) done_cyc = cyc;
      chk("cpu_rst_vs_done", {31'b0, cpu_rst}, {31'b0, ~done});
      prev_rdy  = in_ready;
      prev_init = initialize;
      prev_done = done;
    end
  end

  task automatic send_byte(input logic [7:0] b, output bit ok);
    bit got;
    got = 1'b0;
    in_valid = 1'b1;
    in_data  = b;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) break;
    end
    in_valid = 1'b0;
    ok = got;
  endtask

  task automatic run_load(input int n, input bit rnd, input int gap_at, input int gap_len);
    int s, stall, g;
    bit ok;
    for (int w = 0; w < n; w++)
      exp_q.push_back({BASE + 32'(4 * w), bb[4*w], bb[4*w+1], bb[4*w+2], bb[4*w+3]});
    first_acc = -1; last_wr = -1; init_fall = -1; done_cyc = -1; stall = 0;
    @(posedge clk); #1;
    start = 1'b1;
    num_words = 8'(n);
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    num_words = 8'($urandom);
    for (int k = 0; k < 4 * n; k++) begin
      g = 0;
      if (k % 4 != 0) begin
        if (rnd) g = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        else if (k == gap_at) g = gap_len;
      end
      for (int j = 0; j < g; j++) begin
        in_valid  = 1'b0;
        in_data   = 8'($urandom);
        start     = rnd && (j == 0) && ($urandom_range(0, 1) == 1);
        num_words = 8'($urandom);
        @(posedge clk); #1;
        start = 1'b0;
      end
      stall += g;
      send_byte(bb[k], ok);
      if (!ok) begin
        chk("byte_accept_timeout", 32'(k), 32'hFFFF_FFFF);
        return;
      end
    end
    // Bytes offered during WRITE/RELEASE must not be consumed.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    for (int k = 0; k < 100 && done_cyc < 0; k++) @(negedge clk);
    if (done_cyc < 0) chk("done_timeout", 32'(done_cyc), 32'(s));
    if (n > 0) begin
      chk("first_accept_cycle", 32'(first_acc), 32'(s + 1));
      chk("last_write_cycle", 32'(last_wr), 32'(s + 5 * n + stall));
      chk("init_fall_cycle", 32'(init_fall), 32'(last_wr + 1));
      chk("done_cycle", 32'(done_cyc), 32'(last_wr + RSTC + 1));
    end else begin
      chk("zero_no_write", 32'(last_wr), 32'hFFFF_FFFF);
      chk("zero_init_fall", 32'(init_fall), 32'(s + 2));
      chk("zero_done_cycle", 32'(done_cyc), 32'(s + RSTC + 1));
    end
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    for (int w = 0; w < n; w++) begin
      logic [31:0] a;
      a = BASE + 32'(4 * w);
      chk("readback", mem.exists(a) ? mem[a] : 32'hDEAD_BEEF,
          {bb[4*w], bb[4*w+1], bb[4*w+2], bb[4*w+3]});
    end
  endtask

  initial begin
    bit ok;
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("por_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    chk("por_initialize", {31'b0, initialize}, 32'd0);
    chk("por_done", {31'b0, done}, 32'd0);
    chk("por_busy", {31'b0, busy}, 32'd0);
    chk("por_in_ready", {31'b0, in_ready}, 32'd0);
    chk("por_addr", instruction_initialize_address, BASE);
    chk("por_data", instruction_initialize_data, 32'd0);
    rst = 1'b0;

    {bb[0], bb[1], bb[2], bb[3], bb[4], bb[5], bb[6], bb[7]} = 64'h20_08_00_05_00_00_00_08;
    run_load(2, 1'b0, -1, 0);
    chk("two_word_w0", mem[BASE], 32'h2008_0005);
    chk("two_word_w1", mem[BASE + 32'd4], 32'h0000_0008);
    chk("cpu_running", {31'b0, cpu_rst}, 32'd0);

    run_load(2, 1'b0, 2, 3);
    run_load(0, 1'b0, -1, 0);

    for (int k = 0; k < 8; k++) bb[k] = 8'($urandom);
    exp_q.push_back({BASE, bb[0], bb[1], bb[2], bb[3]});
    @(posedge clk); #1;
    start = 1'b1; num_words = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      send_byte(bb[k], ok);
      if (!ok) chk("rst_test_accept", 32'(k), 32'hFFFF_FFFF);
    end
    #2 rst = 1'b1;
    #1;
    chk("midrst_initialize", {31'b0, initialize}, 32'd0);
    chk("midrst_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_scoreboard", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) bb[k] = 8'($urandom);
    run_load(1, 1'b0, -1, 0);

    for (int t = 0; t < 8; t++) begin
      n = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      for (int k = 0; k < 4 * n; k++) bb[k] = 8'($urandom);
      run_load(n, 1'b1, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
